// File: rtl/axi4s_packet_fifo_pkg.sv
// rtl/axi4s_packet_fifo_pkg.sv - ingress state type and stored-word width helper for the AXI4-S packet FIFO
package axi4s_packet_fifo_pkg;

  typedef enum logic [0:0] {
    WRITE_E   = 1'b0,
    DISCARD_E = 1'b1
  } ingress_state_e;

  // Width of one stored beat, packed as {data, strb, keep, last, id, dest, user}.
  function automatic int word_width(
    input int data_w,
    input int strb_w,
    input int keep_w,
    input int id_w,
    input int dest_w,
    input int user_w
  );
    return data_w + strb_w + keep_w + 1 + id_w + dest_w + user_w;
  endfunction

endpackage

// File: rtl/axi4s_packet_fifo_ram.sv
// rtl/axi4s_packet_fifo_ram.sv - simple dual-port beat storage, synchronous write, asynchronous read
module axi4s_packet_fifo_ram #(
  parameter int ADDR_WIDTH_P = 4,
  parameter int WORD_WIDTH_P = 8
) (
  input  logic                    clk,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH_P-1:0] wr_addr,
  input  logic [WORD_WIDTH_P-1:0] wr_data,
  input  logic [ADDR_WIDTH_P-1:0] rd_addr,
  output logic [WORD_WIDTH_P-1:0] rd_data
);

  logic [WORD_WIDTH_P-1:0] mem_q [2**ADDR_WIDTH_P];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/axi4s_packet_fifo.sv
// rtl/axi4s_packet_fifo.sv - store-and-forward AXI4-S packet FIFO; packets are visible only once committed.
// AXI4S_PACKET_FIFO_DROP_EN: always ready, packets overflowing a full FIFO are dropped instead of backpressured.
module axi4s_packet_fifo
  import axi4s_packet_fifo_pkg::*;
#(
  parameter int AXI_DATA_WIDTH_P  = 32,
  parameter int AXI_STRB_WIDTH_P  = 4,
  parameter int AXI_KEEP_WIDTH_P  = 4,
  parameter int AXI_ID_WIDTH_P    = 4,
  parameter int AXI_DEST_WIDTH_P  = 4,
  parameter int AXI_USER_WIDTH_P  = 4,
  parameter int FIFO_ADDR_WIDTH_P = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           mst_tvalid,
  output logic                           mst_tready,
  input  logic [AXI_DATA_WIDTH_P-1:0]    mst_tdata,
  input  logic [AXI_STRB_WIDTH_P-1:0]    mst_tstrb,
  input  logic [AXI_KEEP_WIDTH_P-1:0]    mst_tkeep,
  input  logic                           mst_tlast,
  input  logic [AXI_ID_WIDTH_P-1:0]      mst_tid,
  input  logic [AXI_DEST_WIDTH_P-1:0]    mst_tdest,
  input  logic [AXI_USER_WIDTH_P-1:0]    mst_tuser,
  output logic                           slv_tvalid,
  input  logic                           slv_tready,
  output logic [AXI_DATA_WIDTH_P-1:0]    slv_tdata,
  output logic [AXI_STRB_WIDTH_P-1:0]    slv_tstrb,
  output logic [AXI_KEEP_WIDTH_P-1:0]    slv_tkeep,
  output logic                           slv_tlast,
  output logic [AXI_ID_WIDTH_P-1:0]      slv_tid,
  output logic [AXI_DEST_WIDTH_P-1:0]    slv_tdest,
  output logic [AXI_USER_WIDTH_P-1:0]    slv_tuser,
  output logic [FIFO_ADDR_WIDTH_P:0]     fifo_fill,
  output logic [FIFO_ADDR_WIDTH_P:0]     nr_of_packets,
  output logic                           pkt_dropped
);

  localparam int DEPTH  = 2**FIFO_ADDR_WIDTH_P;
  localparam int PTR_W  = FIFO_ADDR_WIDTH_P + 1;
  localparam int WORD_W = word_width(AXI_DATA_WIDTH_P, AXI_STRB_WIDTH_P, AXI_KEEP_WIDTH_P,
                                     AXI_ID_WIDTH_P, AXI_DEST_WIDTH_P, AXI_USER_WIDTH_P);

  ingress_state_e   state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] cmt_ptr_q, cmt_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] pkt_cnt_q, pkt_cnt_d;
  logic             pkt_dropped_q, pkt_dropped_d;

  logic [PTR_W-1:0]  fill;
  logic              full;
  logic              drop_beat;
  logic              wr_fire;
  logic              rd_fire;
  logic              mem_we;
  logic              commit;
  logic [WORD_W-1:0] wr_word;
  logic [WORD_W-1:0] rd_word;

  logic [AXI_DATA_WIDTH_P-1:0] rd_tdata;
  logic [AXI_STRB_WIDTH_P-1:0] rd_tstrb;
  logic [AXI_KEEP_WIDTH_P-1:0] rd_tkeep;
  logic                        rd_tlast;
  logic [AXI_ID_WIDTH_P-1:0]   rd_tid;
  logic [AXI_DEST_WIDTH_P-1:0] rd_tdest;
  logic [AXI_USER_WIDTH_P-1:0] rd_tuser;

  assign fill = wr_ptr_q - rd_ptr_q;
  assign full = (fill == PTR_W'(DEPTH));

`ifdef AXI4S_PACKET_FIFO_DROP_EN
  assign mst_tready = !rst;
  assign drop_beat  = full;
`else
  assign mst_tready = !rst && !full;
  assign drop_beat  = 1'b0;
`endif

  assign wr_fire    = mst_tvalid && mst_tready;
  assign slv_tvalid = (pkt_cnt_q != '0);
  assign rd_fire    = slv_tvalid && slv_tready;

  assign wr_word = {mst_tdata, mst_tstrb, mst_tkeep, mst_tlast, mst_tid, mst_tdest, mst_tuser};
  assign {rd_tdata, rd_tstrb, rd_tkeep, rd_tlast, rd_tid, rd_tdest, rd_tuser} = rd_word;

  axi4s_packet_fifo_ram #(
    .ADDR_WIDTH_P (FIFO_ADDR_WIDTH_P),
    .WORD_WIDTH_P (WORD_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (mem_we),
    .wr_addr (wr_ptr_q[FIFO_ADDR_WIDTH_P-1:0]),
    .wr_data (wr_word),
    .rd_addr (rd_ptr_q[FIFO_ADDR_WIDTH_P-1:0]),
    .rd_data (rd_word)
  );

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    cmt_ptr_d     = cmt_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    pkt_cnt_d     = pkt_cnt_q;
    pkt_dropped_d = 1'b0;
    mem_we        = 1'b0;
    commit        = 1'b0;

    case (state_q)
      WRITE_E: begin
        if (wr_fire) begin
          if (drop_beat) begin
            // Rewind to the last committed packet; earlier packets stay intact.
            wr_ptr_d      = cmt_ptr_q;
            pkt_dropped_d = 1'b1;
            if (!mst_tlast) begin
              state_d = DISCARD_E;
            end
          end else begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (mst_tlast) begin
              cmt_ptr_d = wr_ptr_q + PTR_W'(1);
              commit    = 1'b1;
            end
          end
        end
      end
      DISCARD_E: begin
        if (wr_fire && mst_tlast) begin
          state_d = WRITE_E;
        end
      end
      default: state_d = WRITE_E;
    endcase

    if (rd_fire) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    if (commit && !(rd_fire && rd_tlast)) begin
      pkt_cnt_d = pkt_cnt_q + PTR_W'(1);
    end else if (!commit && rd_fire && rd_tlast) begin
      pkt_cnt_d = pkt_cnt_q - PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= WRITE_E;
      wr_ptr_q      <= '0;
      cmt_ptr_q     <= '0;
      rd_ptr_q      <= '0;
      pkt_cnt_q     <= '0;
      pkt_dropped_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      cmt_ptr_q     <= cmt_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      pkt_cnt_q     <= pkt_cnt_d;
      pkt_dropped_q <= pkt_dropped_d;
    end
  end

  assign slv_tdata     = slv_tvalid ? rd_tdata : '0;
  assign slv_tstrb     = slv_tvalid ? rd_tstrb : '0;
  assign slv_tkeep     = slv_tvalid ? rd_tkeep : '0;
  assign slv_tlast     = slv_tvalid ? rd_tlast : 1'b0;
  assign slv_tid       = slv_tvalid ? rd_tid   : '0;
  assign slv_tdest     = slv_tvalid ? rd_tdest : '0;
  assign slv_tuser     = slv_tvalid ? rd_tuser : '0;
  assign fifo_fill     = fill;
  assign nr_of_packets = pkt_cnt_q;
  assign pkt_dropped   = pkt_dropped_q;

endmodule
